// File: rtl/fp_pkg.sv
// Shared types and constants for the post-multiply normalise/round stage.
// Exponent arithmetic is two's complement on EXW bits; significands carry the hidden bit.
package fp_pkg;
    localparam int EW   = 8;
    localparam int FW   = 7;
    localparam int BIAS = 2**(EW-1) - 1;
    localparam int EXW  = EW + 2;
    localparam int SW   = FW + 1;

    localparam int OOR_OVF  = 0;
    localparam int OOR_UNF  = 1;
    localparam int OOR_INX  = 2;
    localparam int OOR_ZERO = 3;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } round_mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NORM   = 3'd1,
        S_DENORM = 3'd2,
        S_ROUND  = 3'd3,
        S_POST   = 3'd4,
        S_DONE   = 3'd5
    } rn_state_e;
endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision: given the kept lsb, guard, sticky, sign and mode,
// says whether to increment the significand and whether the result is inexact.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic       sign,
    input  logic [1:0] mode,
    output logic       inc,
    output logic       inexact
);
    always_comb begin
        inexact = guard | sticky;
        inc     = 1'b0;
        case (round_mode_e'(mode))
            RNE: inc = guard & (sticky | lsb);
            RTZ: inc = 1'b0;
            RUP: inc = inexact & ~sign;
            RDN: inc = inexact & sign;
        endcase
    end
endmodule

// File: rtl/fp_round_norm.sv
// Normalise, subnormal-shift, round and range-check a raw significand product.
// Handshake: start_in is taken only while ready_out=1 (IDLE); valid_out pulses once per accepted op.
module fp_round_norm
    import fp_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in_N,
    input  logic              start_in,
    input  logic              sign_in,
    input  logic [EXW-1:0]    exp_in,
    input  logic [2*FW+1:0]   prod_in,
    input  logic              zero_in,
    input  logic [1:0]        round_in,
    output logic [EW+FW:0]    p_out,
    output logic [3:0]        oor_out,
    output logic              valid_out,
    output logic              ready_out,
    output logic [2:0]        state_out
);
    localparam logic [EXW-1:0] E_MAX = EXW'(2*BIAS + 1);
    localparam logic [3:0]     CNT_LAST = 4'(FW + 2);

    rn_state_e state, state_nx;

    logic              sign_r, zero_r;
    logic [EXW-1:0]    exp_r;
    logic [2*FW+1:0]   prod_r;
    logic [1:0]        mode_r;

    logic [SW-1:0]     sig;
    logic              guard, sticky, tiny, carry, inexact_r;
    logic [EXW-1:0]    e;
    logic [3:0]        cnt;

    logic [SW-1:0]     n_sig;
    logic              n_guard, n_sticky, n_le_zero;
    logic [EXW-1:0]    n_e;
    logic              is_zero;

    logic              dec_inc, dec_inexact;
    logic [SW-1:0]     post_sig;
    logic [EXW-1:0]    post_e;
    logic [EW-1:0]     field;
    logic              ovf, to_inf;
    logic [EW+FW:0]    post_p;
    logic [3:0]        post_oor;

    fp_round_decide u_decide (
        .lsb     (sig[0]),
        .guard   (guard),
        .sticky  (sticky),
        .sign    (sign_r),
        .mode    (mode_r),
        .inc     (dec_inc),
        .inexact (dec_inexact)
    );

    // Pick the leading-one position: product of two [1,2) values lies in [1,4).
    always_comb begin
        if (prod_r[2*FW+1]) begin
            n_sig    = prod_r[2*FW+1:FW+1];
            n_guard  = prod_r[FW];
            n_sticky = |prod_r[FW-1:0];
            n_e      = exp_r + EXW'(1);
        end else begin
            n_sig    = prod_r[2*FW:FW];
            n_guard  = prod_r[FW-1];
            n_sticky = |prod_r[FW-2:0];
            n_e      = exp_r;
        end
        n_le_zero = n_e[EXW-1] | (n_e == '0);
        is_zero   = zero_r | (prod_r == '0);
    end

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_in) state_nx = S_NORM;
            S_NORM: begin
                if (is_zero)        state_nx = S_DONE;
                else if (n_le_zero) state_nx = S_DENORM;
                else                state_nx = S_ROUND;
            end
            S_DENORM: if (e == '0 || cnt == CNT_LAST) state_nx = S_ROUND;
            S_ROUND:  state_nx = S_POST;
            S_POST:   state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        valid_out = (state == S_DONE);
        ready_out = (state == S_IDLE);
        state_out = state;
    end

    // A tiny result sits at e=1, so its field is just the (possibly rounded-in) hidden bit.
    always_comb begin
        post_sig = sig;
        post_e   = e;
        if (carry) begin
            post_sig = {1'b1, {FW{1'b0}}};
            post_e   = e + EXW'(1);
        end
        field = tiny ? {{(EW-1){1'b0}}, post_sig[FW]} : post_e[EW-1:0];
        ovf   = !tiny && (post_e >= E_MAX);
        to_inf = (round_mode_e'(mode_r) == RNE) ||
                 (round_mode_e'(mode_r) == RUP && !sign_r) ||
                 (round_mode_e'(mode_r) == RDN && sign_r);
        post_p   = {sign_r, field, post_sig[FW-1:0]};
        post_oor = '0;
        post_oor[OOR_INX] = inexact_r;
        post_oor[OOR_UNF] = tiny;
        if (ovf) begin
            post_p = to_inf ? {sign_r, {EW{1'b1}}, {FW{1'b0}}}
                            : {sign_r, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            post_oor[OOR_OVF] = 1'b1;
            post_oor[OOR_INX] = 1'b1;
        end
        post_oor[OOR_ZERO] = tiny && (post_sig == '0);
    end

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            exp_r     <= '0;
            prod_r    <= '0;
            mode_r    <= '0;
            sig       <= '0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            tiny      <= 1'b0;
            carry     <= 1'b0;
            inexact_r <= 1'b0;
            e         <= '0;
            cnt       <= '0;
            p_out     <= '0;
            oor_out   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_in) begin
                    sign_r <= sign_in;
                    zero_r <= zero_in;
                    exp_r  <= exp_in;
                    prod_r <= prod_in;
                    mode_r <= round_in;
                end
                S_NORM: begin
                    sig    <= n_sig;
                    guard  <= n_guard;
                    sticky <= n_sticky;
                    e      <= n_e;
                    tiny   <= n_le_zero;
                    carry  <= 1'b0;
                    cnt    <= '0;
                    if (is_zero) begin
                        p_out   <= {sign_r, {(EW+FW){1'b0}}};
                        oor_out <= 4'b1000;
                    end
                end
                S_DENORM: begin
                    cnt <= cnt + 4'd1;
                    // Everything has been shifted past the guard bit; only sticky survives.
                    if (cnt == CNT_LAST) begin
                        sig    <= '0;
                        guard  <= 1'b0;
                        sticky <= 1'b1;
                        e      <= EXW'(1);
                    end else begin
                        sticky <= sticky | guard;
                        guard  <= sig[0];
                        sig    <= sig >> 1;
                        e      <= e + EXW'(1);
                    end
                end
                S_ROUND: begin
                    {carry, sig} <= {1'b0, sig} + {{SW{1'b0}}, dec_inc};
                    inexact_r    <= dec_inexact;
                end
                S_POST: begin
                    p_out   <= post_p;
                    oor_out <= post_oor;
                end
                default: ;
            endcase
        end
    end
endmodule
